// File: rtl/mem_if.sv
// mem_if: req/ready memory access bus between the core (master) and the memory responder (slave).
interface mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  modport master(output req, we, addr, wdata, input ready, rdata, err);
  modport slave(input req, we, addr, wdata, output ready, rdata, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: unified word memory answering req with a one-cycle ready after LATENCY wait states.
// Optional MEM_ERR_EN flags out-of-range addresses with err and suppresses their effect.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input logic   clk_i,
  input logic   reset_ni,
  mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LOAD = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, c_idx;
  logic          we_q, c_we, c_oor, accept, commit;
  logic [31:0]   wdata_q, c_wdata, rdata_q;
  logic [31:0]   mem [DEPTH_WORDS];
  always_comb begin
    accept  = state_q == IDLE && bus.req;
    state_d = state_q == RESP ? IDLE
            : state_q == WAIT ? (cnt_q == 4'd0 ? RESP : WAIT)
            : accept ? (LATENCY > 0 ? WAIT : RESP) : IDLE;
    cnt_d   = state_q == WAIT ? (cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1)
            : accept ? LOAD : cnt_q;
    commit  = reset_ni && state_d == RESP && state_q != RESP;
  end
  // With zero wait states the commit edge is the acceptance edge, so bypass the captures.
  assign c_idx   = accept ? bus.addr[AW+1:2] : idx_q;
  assign c_we    = accept ? bus.we : we_q;
  assign c_wdata = accept ? bus.wdata : wdata_q;
`ifdef MEM_ERR_EN
  logic oor_q, err_q;
  logic unused_addr;
  assign unused_addr = ^bus.addr[1:0];
  assign c_oor   = accept ? |bus.addr[31:AW+2] : oor_q;
  assign bus.err = err_q;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) oor_q <= |bus.addr[31:AW+2];
      err_q <= commit && c_oor;
    end
`else
  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  assign c_oor   = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= bus.addr[AW+1:2];
        we_q    <= bus.we;
        wdata_q <= bus.wdata;
      end
      if (commit && !c_we) rdata_q <= c_oor ? 32'h0 : mem[c_idx];
    end
  always_ff @(posedge clk_i)
    if (commit && c_we && !c_oor) mem[c_idx] <= c_wdata;
  assign bus.ready = state_q == RESP;
  assign bus.rdata = rdata_q;
endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory responder for the multicycle ARM core. It serves the controller's fetch, load and store accesses over a req/ready handshake with a configurable number of wait states. This replaces the ideal single-cycle memory so the controller can be exercised against realistic latency. It sits between the datapath address/write-data mux and the instruction/data registers.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words; power of two, ≥4.
- LATENCY, 2: wait-state cycles per access, 0..15.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request.
- we  in  1  1 = store, 0 = fetch/load.
- addr  in  32  byte address; addr[1:0] ignored (word access only).
- wdata  in  32  store data.
- ready  out  1  one-cycle completion strobe.
- rdata  out  32  read data, valid while ready=1.
- err  out  1  address-range error, valid while ready=1 (tied 0 unless MEM_ERR_EN).

## Operation
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req=1 at a rising edge, the access is accepted. addr, we and wdata are captured into internal registers. The down-counter is loaded with LATENCY-1. Next state is WAIT if LATENCY>0, else RESP. If req=0, the FSM stays in IDLE.
- WAIT: the counter decrements each edge. At the edge where counter=0, the FSM moves to RESP.
- Edge entering RESP (commit edge):
  - Store: mem[index] ← captured wdata.
  - Load: rdata ← mem[index].
  - Store: rdata is unchanged.
- RESP: ready=1 for exactly one cycle, then IDLE unconditionally. req is ignored in RESP and WAIT.
- Inputs are used only at the acceptance edge. Changes to addr, we or wdata after acceptance have no effect.
- If req is still high in the IDLE cycle after RESP, a new access is accepted. Back-to-back accesses therefore have one IDLE cycle between them.
- rdata holds its last loaded value outside RESP. err is 0 outside RESP.
- Store then load to the same word returns the stored value. No bypass is needed because the accesses are serialized.

## Timing
- Reset values: state=IDLE, ready=0, rdata=32'h0000_0000, err=0, counter=0.
- Latency: a req accepted at edge E gives ready=1 in the cycle after edge E+LATENCY.
  - Access period is LATENCY+2 cycles including the IDLE cycle.
  - LATENCY=0: ready appears in the cycle right after acceptance.
- Reset asserted mid-access (WAIT, or IDLE with req) returns to IDLE at once. A store whose commit edge has not occurred is never written. ready does not assert for the aborted access.
- Reset deasserted with req=1: acceptance happens at the first rising edge after deassertion.
- The requester must keep req low during RESP unless it intends a new access.

## Configuration
- MEM_ERR_EN defined:
  - captured addr ≥ DEPTH_WORDS*4 sets err=1 together with ready.
  - Out-of-range store: suppressed, memory unchanged.
  - Out-of-range load: rdata ← 32'h0000_0000.
  - In-range accesses give err=0.
- MEM_ERR_EN undefined: upper address bits are ignored, so the address wraps modulo DEPTH_WORDS*4. err is constant 0 and no range compare logic is present.

## Test plan
- Reset: hold reset=0 for 3 cycles with req=1 → ready=0, rdata=0, err=0 throughout; first acceptance at the first edge after release.
- Store/load, LATENCY=2: store 32'hCAFE_F00D at addr 0x10, then load 0x10 → each ready exactly 3 cycles after acceptance, one cycle wide; load rdata=32'hCAFE_F00D.
- LATENCY=0, req held high for 6 cycles, alternating store/load to 0x0/0x4 → ready pulses every 2nd cycle; data matches.
- Address change after acceptance: accept load of 0x8 (holds 0x1111_1111), switch addr to 0xC (holds 0x2222_2222) during WAIT → rdata=0x1111_1111.
- Reset mid-access: accept store of 0xAAAA_AAAA to 0x20 (old 0x5555_5555), pull reset low in the first WAIT cycle, release, load 0x20 → 0x5555_5555; no ready for the aborted store.
- Range, DEPTH_WORDS=64:
  - With MEM_ERR_EN, store to 0x100 → err=1 with ready, memory unchanged.
  - With MEM_ERR_EN, load 0x100 → rdata=0, err=1.
  - Without MEM_ERR_EN, store 0x1234_5678 to 0x100, load 0x0 → 0x1234_5678, err=0.
